dmi_jtag_access: RTL
====================

Name: dmi_jtag_access

Overview:
- TCK-domain DMI access controller of the DTM, directly upstream of the DMI CDC (request/response FIFO pair).
- Turns Update-DR of the JTAG `dmi` register into one `dm::dmi_req_t` transaction on a valid/ready interface.
- Waits for the matching `dm::dmi_resp_t`, then holds the result for the next Capture-DR.
- Maintains the sticky `dmistat` error and handles dmireset/dmihardreset.

Parameters:
- AddrWidth, 7, DMI address bits; `dmi` register width = AddrWidth+34.

Ports:
- clk_i  in  1  TCK.
- rst_i  in  1  asynchronous, active-high reset (TRST-derived).
- capture_i  in  1  one-cycle Capture-DR pulse, `dmi` selected.
- update_i  in  1  one-cycle Update-DR pulse, `dmi` selected.
- dmi_wdata_i  in  AddrWidth+34  shifted value {addr, data[31:0], op[1:0]}.
- dmi_rdata_o  out  AddrWidth+34  capture value {addr_q, data_q, status[1:0]}.
- dmireset_i  in  1  dtmcs.dmireset pulse.
- dmihardreset_i  in  1  dtmcs.dmihardreset pulse.
- dmistat_o  out  2  sticky error, for dtmcs.
- dmi_req_o  out  $bits(dm::dmi_req_t)  request to CDC.
- dmi_req_valid_o  out  1
- dmi_req_ready_i  in  1
- dmi_resp_i  in  $bits(dm::dmi_resp_t)  response from CDC.
- dmi_resp_valid_i  in  1
- dmi_resp_ready_o  out  1

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; addr_q, data_q, op_q, error_q, discard_q all 0.
  - All outputs 0: dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_rdata_o=0, dmistat_o=0.
- Reset mid-transaction: drop to IDLE; the CDC's own reset clears any in-flight data.
- FSM IDLE -> REQ:
  - Requires update_i && error_q==OK && op∈{READ,WRITE}.
  - Latch addr_q, data_q, op_q from dmi_wdata_i.
  - dmi_req_valid_o rises the next cycle (1-cycle latency).
- FSM in IDLE, no request:
  - op==NOP or reserved (3): no request, registers unchanged.
  - error_q!=OK: update ignored entirely.
- FSM REQ -> WAIT:
  - dmi_req_valid_o=1 and dmi_req_o={addr_q, op_q, data_q}, stable until dmi_req_ready_i.
  - Advance on dmi_req_ready_i. Valid is never withdrawn before ready.
- FSM WAIT -> IDLE:
  - dmi_resp_ready_o=1 only in WAIT. Advance on dmi_resp_valid_i.
  - If !discard_q: data_q<=resp.data (read and write alike).
  - If !discard_q and resp.resp==FAILED(2) and error_q==OK: error_q<=FAILED.
  - discard_q<=0.
  - Response handshake at cycle t -> new data_q visible at t+1.
- Status field:
  - dmi_rdata_o status = BUSY(3) while state!=IDLE, else error_q.
  - addr/data fields always show addr_q/data_q.
- Busy violations:
  - capture_i or update_i while state!=IDLE: error_q<=BUSY if error_q==OK.
  - An update while busy never alters addr_q/data_q/op_q and never issues a request.
- dmireset_i: error_q<=OK. Wins over any same-cycle error set. Does not affect an in-flight transaction.
- dmihardreset_i:
  - error_q<=OK.
  - If state!=IDLE: discard_q<=1; the transaction still completes its handshakes (CDC cannot be aborted) and its response is dropped.
  - update_i in the same cycle as dmihardreset_i is ignored.
- Simultaneous update_i with response completion in WAIT counts as busy (state!=IDLE in that cycle).
- dmistat_o=error_q.
- Only one transaction is ever outstanding.

Decomposition:
- dm package:
  - dmi_req_t {addr[6:0], op[1:0], data[31:0]}
  - dmi_resp_t {data[31:0], resp[1:0]}
  - dtm_op_e: NOP=0, READ=1, WRITE=2
  - dmi_error_e: OK=0, FAILED=2, BUSY=3
  - DMI address-width constant
- State enum local. No sub-module; a single flat FSM.

Test Plan:
- Reset asserted mid-WAIT -> next cycle all outputs 0, state IDLE, dmistat_o=0.
- Update {addr=0x10, data=0, op=READ}; CDC ready after 2 cycles, resp {0xDEADBEEF, OK} 5 cycles later -> one request with addr 0x10, op 1; next capture returns {0x10, 0xDEADBEEF, 0}.
- Update WRITE addr 0x04 data 0x1; second update during WAIT -> dmistat_o=3, only one request seen; subsequent update ignored until dmireset_i, then a READ proceeds normally.
- Response resp=2 -> dmistat_o=2; capture status=2; a new update issues no request.
- Capture during REQ -> status field 3 in that capture, dmistat_o=3 next cycle; dmireset_i coincident with that capture -> dmistat_o stays 0.
- dmihardreset_i during WAIT, then resp {0x12345678, FAILED} -> data_q unchanged, dmistat_o=0, state IDLE; the next READ completes normally.

Source files
------------

// File: rtl/dm.sv
// rtl/dm.sv - Debug-module DMI transaction types shared by the DTM and the DMI CDC.
//
// Purpose: request/response structs and opcode/status encodings of the DMI.
// Ports:   none (package).
package dm;

  localparam int DmiAddrWidth = 7;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    OK     = 2'd0,
    FAILED = 2'd2,
    BUSY   = 2'd3
  } dmi_error_e;

  typedef struct packed {
    logic [DmiAddrWidth-1:0] addr;
    dtm_op_e                 op;
    logic [31:0]             data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_jtag_access.sv
// rtl/dmi_jtag_access.sv - TCK-domain DMI access controller: Update-DR to DMI request, response to Capture-DR.
//
// Purpose: issues one DMI request per accepted Update-DR of the `dmi` register,
//          waits for its response, keeps the result for the next Capture-DR and
//          maintains the sticky dmistat error.
// Ports:
//   clk_i, rst_i              TCK and asynchronous active-high reset
//   capture_i, update_i       Capture-DR / Update-DR pulses with `dmi` selected
//   dmi_wdata_i               shifted-in {addr, data, op}
//   dmi_rdata_o               capture value {addr_q, data_q, status}
//   dmireset_i, dmihardreset_i dtmcs reset pulses
//   dmistat_o                 sticky error
//   dmi_req_*                 request channel towards the CDC
//   dmi_resp_*                response channel from the CDC
module dmi_jtag_access
  import dm::*;
#(
  parameter int AddrWidth = DmiAddrWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          capture_i,
  input  logic                          update_i,
  input  logic [AddrWidth+33:0]         dmi_wdata_i,
  output logic [AddrWidth+33:0]         dmi_rdata_o,
  input  logic                          dmireset_i,
  input  logic                          dmihardreset_i,
  output logic [1:0]                    dmistat_o,
  output logic [$bits(dmi_req_t)-1:0]   dmi_req_o,
  output logic                          dmi_req_valid_o,
  input  logic                          dmi_req_ready_i,
  input  logic [$bits(dmi_resp_t)-1:0]  dmi_resp_i,
  input  logic                          dmi_resp_valid_i,
  output logic                          dmi_resp_ready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [31:0]            data_q;
  logic [1:0]             op_q;
  logic [1:0]             error_q;
  logic [1:0]             error_d;
  logic                   discard_q;
  logic                   req_valid_q;
  logic                   resp_ready_q;

  logic [AddrWidth-1:0]   wr_addr;
  logic [31:0]            wr_data;
  logic [1:0]             wr_op;
  dmi_resp_t              resp;
  logic                   busy;
  logic                   start;
  logic                   resp_fire;
  logic                   drop;

  assign wr_addr = dmi_wdata_i[AddrWidth+33:34];
  assign wr_data = dmi_wdata_i[33:2];
  assign wr_op   = dmi_wdata_i[1:0];
  assign resp    = dmi_resp_t'(dmi_resp_i);

  assign busy      = (state_q != IDLE);
  // An update coinciding with dmihardreset is ignored, as is any update while an error is pending.
  assign start     = (state_q == IDLE) && update_i && !dmihardreset_i && (error_q == OK) &&
                     ((wr_op == READ) || (wr_op == WRITE));
  assign resp_fire = (state_q == WAIT) && dmi_resp_valid_i;
  // A hardreset arriving in the very cycle of the response drops that response too.
  assign drop      = discard_q || dmihardreset_i;

  // Sticky error: FAILED from the response, BUSY from DR activity while busy,
  // and the two reset pulses override anything set in the same cycle.
  always_comb begin
    error_d = error_q;
    if (resp_fire && !drop && (resp.resp == FAILED) && (error_q == OK)) error_d = FAILED;
    if (busy && (capture_i || update_i) && (error_q == OK)) error_d = BUSY;
    if (dmireset_i || dmihardreset_i) error_d = OK;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= '0;
      error_q      <= '0;
      discard_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
    end else begin
      error_q <= error_d;
      if (dmihardreset_i && busy) discard_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q      <= wr_addr;
            data_q      <= wr_data;
            op_q        <= wr_op;
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (dmi_req_ready_i) begin
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (dmi_resp_valid_i) begin
            resp_ready_q <= 1'b0;
            state_q      <= IDLE;
            if (!drop) data_q <= resp.data;
            // Completion ends the transaction, so its discard marker must not leak into the next one.
            discard_q    <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign dmi_req_o        = {addr_q, op_q, data_q};
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmistat_o        = error_q;
  assign dmi_rdata_o      = {addr_q, data_q, busy ? 2'(BUSY) : error_q};

endmodule
